regfile_read_arbiter: RTL and testbench

Round-robin arbiter that shares the architectural register file's single pair of operand read ports (rs1/rs2) among several dispatch-side requesters, such as the ALU, MUL, LSU and branch issue paths. It grants one requester per cycle, drives the register-file read selects, and registers the returned operands. During the response cycle it patches those operands with same-cycle ROB commits, so no result is lost between lookup and consumption. It sits between the per-unit dispatch logic and the register file.

---
 rtl/types.sv | 19 +
 rtl/regfile_read_arbiter_if.sv | 17 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/regfile_read_arbiter.sv | 76 +++++++
 tb/tb_regfile_read_arbiter.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/types.sv
// types: shared register-file operand type, ROB sizing and read-port arbiter defaults
//   reg_t          - operand as returned by the register file: valid, data, producing rob_tag
//   ROB_DEPTH      - reorder buffer entries; sets the rob_tag width
//   N_RF_REQ       - default number of register-file read requesters
//   patch_operand  - replaces a pending operand with a matching same-cycle commit
package types;
    localparam int ROB_DEPTH = 16;
    localparam int ROB_TAG_W = $clog2(ROB_DEPTH);
    localparam int N_RF_REQ = 4;
    typedef struct packed {
        logic                 valid;
        logic [31:0]          data;
        logic [ROB_TAG_W-1:0] rob_tag;
    } reg_t;
    localparam reg_t REG_RESET = reg_t'{valid: 1'b1, data: 32'd0, rob_tag: '0};
    function automatic reg_t patch_operand(reg_t r, logic en, logic [ROB_TAG_W-1:0] tag, logic [31:0] val);
        return (!r.valid && en && tag == r.rob_tag) ? reg_t'{valid: 1'b1, data: val, rob_tag: r.rob_tag} : r;
    endfunction
endpackage

// File: rtl/regfile_read_arbiter_if.sv
// regfile_read_arbiter_if: requester-side lookup bus of the register-file read arbiter
//   req_valid/req_rs1/req_rs2 - per-requester lookup request and source registers
//   req_grant                 - one-hot grant, same cycle as the request
//   resp_valid                - one-hot response strobe, one cycle after the grant
//   resp_rs1/resp_rs2         - operands for the responding requester
//   master: requester side, slave: arbiter side
interface regfile_read_arbiter_if #(parameter int N = 4);
    logic [N-1:0]      req_valid;
    logic [N-1:0][4:0] req_rs1;
    logic [N-1:0][4:0] req_rs2;
    logic [N-1:0]      req_grant;
    logic [N-1:0]      resp_valid;
    types::reg_t       resp_rs1;
    types::reg_t       resp_rs2;
    modport master(output req_valid, req_rs1, req_rs2, input req_grant, resp_valid, resp_rs1, resp_rs2);
    modport slave(input req_valid, req_rs1, req_rs2, output req_grant, resp_valid, resp_rs1, resp_rs2);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker
//   i_req      - request vector
//   i_ptr      - highest-priority index
//   i_en       - grant enable; when low no grant is issued
//   o_grant    - one-hot grant
//   o_next_ptr - index after the winner, or i_ptr when nothing is granted
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    input  logic          i_en,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_next_ptr
);
    int w_best;
    int w_dist;
    // Each requester's distance from the pointer going upward with wrap; the nearest wins.
    always_comb begin
        w_best = N;
        w_dist = 0;
        o_grant = '0;
        o_next_ptr = i_ptr;
        for (int i = 0; i < N; i++) begin
            w_dist = (i + N - int'(i_ptr)) % N;
            if (i_en && i_req[i] && w_dist < w_best) begin
                w_best = w_dist;
                o_grant = N'(1) << i;
                o_next_ptr = (i == N - 1) ? '0 : PW'(i + 1);
            end
        end
    end
endmodule

// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter: round-robin sharing of the register file's rs1/rs2 read pair
//   clk, rst           - clock, synchronous active-high reset
//   i_flush            - pipeline flush: blocks grants, hides the pending response
//   bus                - requester lookup bus (slave side)
//   o_rf_rs1_s/_rs2_s  - register-file read selects for the granted requester
//   i_rf_rs1/_rs2      - register-file operands returned in the grant cycle
//   i_commit_*         - ROB commit bus used to patch pending operands in the response cycle
module regfile_read_arbiter
    import types::*;
#(
    parameter int N_REQ = N_RF_REQ,
    localparam int PW = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_flush,
    regfile_read_arbiter_if.slave bus,
    output logic [4:0]           o_rf_rs1_s,
    output logic [4:0]           o_rf_rs2_s,
    input  reg_t                 i_rf_rs1,
    input  reg_t                 i_rf_rs2,
    input  logic                 i_commit_en,
    input  logic [ROB_TAG_W-1:0] i_commit_rob_tag,
    input  logic [31:0]          i_commit_val
);
    logic [PW-1:0]    r_ptr;
    logic [N_REQ-1:0] r_resp_valid;
    reg_t             r_resp_rs1;
    reg_t             r_resp_rs2;
    logic [N_REQ-1:0] w_grant;
    logic [PW-1:0]    w_next_ptr;
    logic [4:0]       w_rs1_s;
    logic [4:0]       w_rs2_s;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .i_req     (bus.req_valid),
        .i_ptr     (r_ptr),
        .i_en      (!rst && !i_flush),
        .o_grant   (w_grant),
        .o_next_ptr(w_next_ptr)
    );

    // One-hot grant makes an OR of masked sources a plain mux; no grant yields 0.
    always_comb begin
        w_rs1_s = '0;
        w_rs2_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_rs1_s = w_rs1_s | (bus.req_rs1[i] & {5{w_grant[i]}});
            w_rs2_s = w_rs2_s | (bus.req_rs2[i] & {5{w_grant[i]}});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
            r_resp_valid <= '0;
            r_resp_rs1 <= REG_RESET;
            r_resp_rs2 <= REG_RESET;
        end else begin
            r_ptr <= w_next_ptr;
            r_resp_valid <= w_grant;
            if (|w_grant) begin
                r_resp_rs1 <= i_rf_rs1;
                r_resp_rs2 <= i_rf_rs2;
            end
        end
    end

    assign bus.req_grant = w_grant;
    assign o_rf_rs1_s = w_rs1_s;
    assign o_rf_rs2_s = w_rs2_s;
    assign bus.resp_valid = i_flush ? '0 : r_resp_valid;
    // Stored operands stay untouched; only the visible copy picks up a matching commit.
    assign bus.resp_rs1 = patch_operand(r_resp_rs1, i_commit_en, i_commit_rob_tag, i_commit_val);
    assign bus.resp_rs2 = patch_operand(r_resp_rs2, i_commit_en, i_commit_rob_tag, i_commit_val);
endmodule

// File: tb/tb_regfile_read_arbiter.sv
// tb_regfile_read_arbiter: directed stimulus checked by a per-cycle behavioural model plus literal expectations
module tb_regfile_read_arbiter;
    import types::*;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           flush = 1'b0;
    logic [4:0]     rf_rs1_s, rf_rs2_s;
    reg_t           rf_rs1, rf_rs2;
    logic           commit_en = 1'b0;
    logic [ROB_TAG_W-1:0] commit_rob_tag = '0;
    logic [31:0]    commit_val = '0;
    reg_t           rf_mem [32];
    int             total = 0;
    int             bad = 0;

    regfile_read_arbiter_if #(.N(N)) bus();

    regfile_read_arbiter #(.N_REQ(N)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_flush         (flush),
        .bus             (bus),
        .o_rf_rs1_s      (rf_rs1_s),
        .o_rf_rs2_s      (rf_rs2_s),
        .i_rf_rs1        (rf_rs1),
        .i_rf_rs2        (rf_rs2),
        .i_commit_en     (commit_en),
        .i_commit_rob_tag(commit_rob_tag),
        .i_commit_val    (commit_val)
    );

    always #5 clk = ~clk;

    always_comb begin
        rf_rs1 = rf_mem[rf_rs1_s];
        rf_rs2 = rf_mem[rf_rs2_s];
    end

    function automatic reg_t mk(logic v, logic [31:0] d, logic [ROB_TAG_W-1:0] t);
        reg_t r;
        r.valid = v;
        r.data = d;
        r.rob_tag = t;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: round-robin pointer, granted requester awaiting response (-1 none), captured operands.
    int   m_ptr = 0;
    int   m_rv = -1;
    reg_t m_r1, m_r2;

    function automatic reg_t model_patch(reg_t r);
        if (r.valid == 1'b0 && commit_en == 1'b1 && commit_rob_tag == r.rob_tag)
            return mk(1'b1, commit_val, r.rob_tag);
        return r;
    endfunction

    always @(negedge clk) begin
        int eg;
        logic [N-1:0] eg_v, erv;
        eg = -1;
        if (!rst && !flush)
            for (int k = 0; k < N; k++)
                if (eg < 0 && bus.req_valid[(m_ptr + k) % N]) eg = (m_ptr + k) % N;
        eg_v = (eg < 0) ? '0 : (N'(1) << eg);
        erv = (flush || m_rv < 0) ? '0 : (N'(1) << m_rv);
        chk("grant", 64'(bus.req_grant), 64'(eg_v));
        chk("rs1_sel", 64'(rf_rs1_s), (eg < 0) ? 64'd0 : 64'(bus.req_rs1[eg]));
        chk("rs2_sel", 64'(rf_rs2_s), (eg < 0) ? 64'd0 : 64'(bus.req_rs2[eg]));
        chk("resp_valid", 64'(bus.resp_valid), 64'(erv));
        if (erv != '0) begin
            chk("resp_rs1", 64'(bus.resp_rs1), 64'(model_patch(m_r1)));
            chk("resp_rs2", 64'(bus.resp_rs2), 64'(model_patch(m_r2)));
        end
        if (rst) begin
            m_ptr = 0;
            m_rv = -1;
            m_r1 = mk(1'b1, 32'd0, '0);
            m_r2 = mk(1'b1, 32'd0, '0);
        end else begin
            m_rv = eg;
            if (eg >= 0) begin
                m_ptr = (eg + 1) % N;
                m_r1 = rf_mem[bus.req_rs1[eg]];
                m_r2 = rf_mem[bus.req_rs2[eg]];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) rf_mem[r] = mk(1'b1, 32'h100 + r, '0);
        rf_mem[0] = mk(1'b1, 32'd0, '0);
        rf_mem[5] = mk(1'b0, 32'd0, 4'd3);
        rf_mem[12] = mk(1'b0, 32'd0, 4'd7);
        bus.req_valid = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_rs1[i] = 5'(i + 1);
            bus.req_rs2[i] = 5'(i + 10);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_grant", 64'(bus.req_grant), 64'd0);
        chk("rst_sel", 64'(rf_rs1_s), 64'd0);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_rs1", 64'(bus.resp_rs1), 64'(mk(1'b1, 32'd0, '0)));
        chk("rst_resp_rs2", 64'(bus.resp_rs2), 64'(mk(1'b1, 32'd0, '0)));
        step();
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("rr_grant", 64'(bus.req_grant), 64'(4'b0001 << (c % 4)));
            chk("rr_sel", 64'(rf_rs1_s), 64'(c % 4 + 1));
            if (c > 0) chk("rr_resp_valid", 64'(bus.resp_valid), 64'(4'b0001 << ((c - 1) % 4)));
            step();
        end
        bus.req_valid = '0;
        #1;
        chk("rr_last_valid", 64'(bus.resp_valid), 64'(4'b1000));
        chk("rr_last_rs1", 64'(bus.resp_rs1), 64'(mk(1'b1, 32'h104, '0)));
        step();
        bus.req_valid = 4'b0100;
        bus.req_rs1[2] = 5'd5;
        bus.req_rs2[2] = 5'd12;
        #1;
        chk("patch_grant", 64'(bus.req_grant), 64'(4'b0100));
        step();
        bus.req_valid = '0;
        commit_en = 1'b1;
        commit_rob_tag = 4'd3;
        commit_val = 32'hDEADBEEF;
        #1;
        chk("patch_valid", 64'(bus.resp_valid), 64'(4'b0100));
        chk("patch_hit_rs1", 64'(bus.resp_rs1), 64'(mk(1'b1, 32'hDEADBEEF, 4'd3)));
        chk("patch_other_rs2", 64'(bus.resp_rs2), 64'(mk(1'b0, 32'd0, 4'd7)));
        commit_rob_tag = 4'd4;
        #1;
        chk("patch_miss_rs1", 64'(bus.resp_rs1), 64'(mk(1'b0, 32'd0, 4'd3)));
        step();
        commit_en = 1'b0;
        bus.req_valid = 4'b0010;
        #1;
        chk("fl_grant1", 64'(bus.req_grant), 64'(4'b0010));
        step();
        bus.req_valid = '0;
        flush = 1'b1;
        #1;
        chk("fl_resp_hidden", 64'(bus.resp_valid), 64'd0);
        step();
        bus.req_valid = 4'b0110;
        #1;
        chk("fl_no_grant", 64'(bus.req_grant), 64'd0);
        step();
        flush = 1'b0;
        #1;
        chk("fl_after_resp", 64'(bus.resp_valid), 64'd0);
        chk("fl_ptr_kept", 64'(bus.req_grant), 64'(4'b0100));
        step();
        bus.req_valid = 4'b0010;
        #1;
        chk("fl_second", 64'(bus.req_grant), 64'(4'b0010));
        step();
        bus.req_valid = 4'b0100;
        #1;
        chk("wr_grant2", 64'(bus.req_grant), 64'(4'b0100));
        step();
        bus.req_valid = 4'b1000;
        #1;
        chk("wr_grant3", 64'(bus.req_grant), 64'(4'b1000));
        step();
        bus.req_valid = 4'b0001;
        #1;
        chk("wr_grant0", 64'(bus.req_grant), 64'(4'b0001));
        chk("wr_resp3", 64'(bus.resp_valid), 64'(4'b1000));
        step();
        bus.req_valid = 4'b0010;
        #1;
        chk("rs_grant1", 64'(bus.req_grant), 64'(4'b0010));
        step();
        rst = 1'b1;
        bus.req_valid = 4'b1111;
        #1;
        chk("rs_hold_grant", 64'(bus.req_grant), 64'd0);
        chk("rs_hold_sel", 64'(rf_rs2_s), 64'd0);
        step();
        rst = 1'b0;
        #1;
        chk("rs_discard", 64'(bus.resp_valid), 64'd0);
        chk("rs_ptr_zero", 64'(bus.req_grant), 64'(4'b0001));
        step();
        bus.req_valid = '0;
        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
